// File: rtl/resize_udiv_seq.sv
// Sequential unsigned divider, 24-bit dividend / 8-bit divisor -> 16-bit saturated quotient.
// Inverts the 16x8->24 resize multiplier using one restoring-division step per cycle.
module resize_udiv_seq #(
  parameter logic [31:0] ID = 32'd1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [23:0] din0,
  input  logic [7:0]  din1,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic        ovf,
  output logic        dz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready is 1 only in IDLE, out_valid is 1 only in DONE, results hold until taken.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [8:0]  r_prem;
  logic [23:0] r_q;
  logic [7:0]  r_div;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_quot;
  logic [7:0]  r_rem;
  logic        r_ovf;
  logic        r_dz;

  logic [8:0]  w_shift;
  logic        w_ge;
  logic [8:0]  w_prem_nxt;
  logic [23:0] w_q_nxt;
  logic        w_unused;

  // r_q starts as the dividend; bits shift out the top into the remainder
  // while quotient bits shift in at the bottom.
  assign w_shift    = {r_prem[7:0], r_q[23]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_prem_nxt = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
  assign w_q_nxt    = {r_q[22:0], w_ge};
  assign w_unused   = ^{ID, r_prem[8]};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_prem      <= 9'd0;
      r_q         <= 24'd0;
      r_div       <= 8'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= 16'h0000;
      r_rem       <= 8'h00;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q        <= din0;
            r_div      <= din1;
            r_prem     <= 9'd0;
            r_cnt      <= 5'd0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_q    <= w_q_nxt;
          r_prem <= w_prem_nxt;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_cnt       <= 5'd0;
            if (r_div == 8'd0) begin
              // Divide-by-zero overrides whatever the step logic produced.
              r_dz   <= 1'b1;
              r_quot <= 16'hFFFF;
              r_rem  <= 8'h00;
              r_ovf  <= 1'b0;
            end else if (|w_q_nxt[23:16]) begin
              r_dz   <= 1'b0;
              r_quot <= 16'hFFFF;
              r_rem  <= w_prem_nxt[7:0];
              r_ovf  <= 1'b1;
            end else begin
              r_dz   <= 1'b0;
              r_quot <= w_q_nxt[15:0];
              r_rem  <= w_prem_nxt[7:0];
              r_ovf  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quot        = r_quot;
  assign rem         = r_rem;
  assign ovf         = r_ovf;
  assign dz          = r_dz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_resize_udiv_seq.sv
// Bench for resize_udiv_seq: directed corner cases, reset abort, output stall,
// and a randomized multiply-then-divide sweep against an arithmetic reference.
module tb_resize_udiv_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic [23:0] din0;
  logic [7:0]  din1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        ovf;
  logic        dz;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] obs_q;
  logic [7:0]  obs_r;
  logic        obs_ovf;

  resize_udiv_seq #(.ID(32'd1)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .din0        (din0),
    .din1        (din1),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .quot        (quot),
    .rem         (rem),
    .ovf         (ovf),
    .dz          (dz),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer division with the saturation / divide-by-zero rules
  task automatic model(input logic [23:0] a, input logic [7:0] b,
                       output logic [15:0] eq, output logic [7:0] er,
                       output logic eovf, output logic edz);
    int unsigned full;
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = 8'h00; eovf = 1'b0; edz = 1'b1;
    end else begin
      full = 32'(a) / 32'(b);
      er   = 8'(32'(a) % 32'(b));
      edz  = 1'b0;
      if (full > 32'hFFFF) begin
        eq = 16'hFFFF; eovf = 1'b1;
      end else begin
        eq = full[15:0]; eovf = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_quot"},      32'(quot),      32'h0000);
    check({tag, "_rem"},       32'(rem),       32'h00);
    check({tag, "_ovf"},       32'(ovf),       32'd0);
    check({tag, "_dz"},        32'(dz),        32'd0);
  endtask

  // driver: one full transaction, with optional consumer stall
  task automatic run_op(input logic [23:0] a, input logic [7:0] b, input int stall,
                        input bit full_checks);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        eovf;
    logic        edz;
    int          n;
    int          lat;
    model(a, b, eq, er, eovf, edz);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    din0 = a; din1 = b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    // scrambled operands while busy must be ignored
    din0 = 24'($urandom); din1 = 8'($urandom); in_valid = 1'($urandom_range(0, 1));
    if (full_checks) check("busy_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'd24);
    check("quot", 32'(quot), 32'(eq));
    check("rem",  32'(rem),  32'(er));
    check("ovf",  32'(ovf),  32'(eovf));
    check("dz",   32'(dz),   32'(edz));
    obs_q = quot; obs_r = rem; obs_ovf = ovf;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_quot",  32'(quot),      32'(eq));
      check("stall_rem",   32'(rem),       32'(er));
      check("stall_ready", 32'(in_ready),  32'd0);
    end
    // offer a new operand in the handshake cycle; it must not be taken
    out_ready = 1'b1; in_valid = 1'b1; din0 = 24'h000001; din1 = 8'h01;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready),  32'd1);
  endtask

  initial begin
    int seen;
    logic [15:0] a;
    logic [7:0]  b;
    ap_rst = 1'b1; din0 = '0; din1 = '0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    check_reset_outputs("rst0");
    #11;
    ap_rst = 1'b0;
    #1;

    // directed cases
    run_op(24'h00C350, 8'h64, 0, 1'b1);
    run_op(24'hFEFF01, 8'hFF, 0, 1'b1);
    run_op(24'hFFFFFF, 8'hFF, 0, 1'b1);
    check("sat_ovf", 32'(obs_ovf), 32'd1);
    run_op(24'h001234, 8'h00, 0, 1'b1);
    run_op(24'h000000, 8'h05, 0, 1'b1);
    run_op(24'h000064, 8'h07, 10, 1'b1);
    run_op(24'hFFFFFF, 8'h01, 1, 1'b1);
    run_op(24'h0000FF, 8'hFF, 0, 1'b1);

    // reset abort in the middle of BUSY
    din0 = 24'h123456; din1 = 8'h03; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    #2;
    ap_rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    #3;
    ap_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_op(24'h000010, 8'h04, 0, 1'b1);
    check("after_abort_quot", 32'(obs_q), 32'h0004);

    // randomized multiply-then-divide sweep
    for (int i = 0; i < 1500; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(1, 255));
      run_op(24'(32'(a) * 32'(b)), b, $urandom_range(0, 2), 1'b0);
      check("inv_quot", 32'(obs_q), 32'(a));
      check("inv_rem",  32'(obs_r), 32'd0);
      check("inv_ovf",  32'(obs_ovf), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
